// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with a start/busy handshake and a watchdog on the transmitter's acknowledge.
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int ACK_TIMEOUT = 16,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int TMR_W      = $clog2(ACK_TIMEOUT)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_busy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      arb_busy,
   output logic                      timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
   logic [TMR_W-1:0]    timer, timer_nxt;
   logic [N_REQ-1:0]    req_ready_nxt;
   logic                tx_start_nxt;
   logic [DATA_W-1:0]   tx_data_nxt;
   logic [ID_W-1:0]     grant_id_nxt;
   logic                timeout_err_nxt;
   logic [ID_W:0]       pick;
   logic [ID_W-1:0]     sel;

   // Returns {found, index} of the first valid requester at or after ptr.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                             input logic [ID_W-1:0]  ptr);
      logic [ID_W:0]   res;
      logic [ID_W-1:0] idx;
      res = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         idx = ID_W'((int'(ptr) + j) % N_REQ);
         if (vld[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign pick = rr_pick(req_valid, rr_ptr);
   assign sel  = pick[ID_W-1:0];

   always_comb begin
      state_nxt       = state;
      rr_ptr_nxt      = rr_ptr;
      timer_nxt       = timer;
      req_ready_nxt   = '0;
      tx_start_nxt    = 1'b0;
      tx_data_nxt     = tx_data;
      grant_id_nxt    = grant_id;
      timeout_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (pick[ID_W]) begin
               req_ready_nxt = N_REQ'(1) << sel;
               tx_data_nxt   = req_data[sel*DATA_W +: DATA_W];
               grant_id_nxt  = sel;
               rr_ptr_nxt    = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: begin
            tx_start_nxt = 1'b1;
            timer_nxt    = '0;
            state_nxt    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // An acknowledge arriving on the last allowed cycle still wins.
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
               timeout_err_nxt = 1'b1;
               state_nxt       = IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         timer       <= '0;
         req_ready   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         arb_busy    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         timer       <= timer_nxt;
         req_ready   <= req_ready_nxt;
         tx_start    <= tx_start_nxt;
         tx_data     <= tx_data_nxt;
         grant_id    <= grant_id_nxt;
         arb_busy    <= (state_nxt != IDLE);
         timeout_err <= timeout_err_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, round-robin order, single requester,
// watchdog timeout, late acknowledge and withdrawn requests.
module tb_uart_tx_arbiter;
   localparam int N_REQ       = 4;
   localparam int DATA_W      = 8;
   localparam int ACK_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Continuous invariants: ready is never multi-hot and never coincides with an error.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         n_cmp++;
         if (!$onehot0(req_ready) || (timeout_err && (req_ready != 4'b0000))) begin
            n_bad++;
            $display("FAIL ready_invariant: req_ready=%b timeout_err=%b, required one-hot or zero and not with error",
                     req_ready, timeout_err);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err} !== 17'h0) begin
         n_bad++; $display("FAIL reset_outputs: got %h required 0",
                           {req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err});
      end
      reset = 1'b1;
      req_data = 32'h0000_0011; req_valid = 4'b0001;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0001 || tx_data !== 8'h11 || arb_busy !== 1'b1) begin
         n_bad++; $display("FAIL pre_grant: ready=%b data=%h busy=%b required 0001/11/1",
                           req_ready, tx_data, arb_busy);
      end
      req_valid = 4'b0000;
      tick();
      n_cmp++;
      if (tx_start !== 1'b1) begin n_bad++; $display("FAIL pre_start: got %b required 1", tx_start); end
      tx_busy = 1'b1;
      tick(); tick();
      n_cmp++;
      if (arb_busy !== 1'b1 || tx_start !== 1'b0) begin
         n_bad++; $display("FAIL pre_wait_done: arb_busy=%b tx_start=%b required 1/0", arb_busy, tx_start);
      end
      // Asynchronous reset in the middle of WAIT_DONE.
      #2 reset = 1'b0; tx_busy = 1'b0;
      #1;
      n_cmp++;
      if ({req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err} !== 17'h0) begin
         n_bad++; $display("FAIL async_reset_outputs: got %h required 0",
                           {req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err});
      end
      n_cmp++;
      if (dut.rr_ptr !== 2'd0) begin n_bad++; $display("FAIL async_reset_rr_ptr: got %0d required 0", dut.rr_ptr); end
      tick(); tick();
      reset = 1'b1;
      req_data = 32'h0000_005A; req_valid = 4'b0001;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0001 || tx_start !== 1'b0 || tx_data !== 8'h5A) begin
         n_bad++; $display("FAIL post_reset_grant: ready=%b start=%b data=%h required 0001/0/5a",
                           req_ready, tx_start, tx_data);
      end
      req_valid = 4'b0000;
      tick();
      n_cmp++;
      if (tx_start !== 1'b1 || req_ready !== 4'b0000) begin
         n_bad++; $display("FAIL post_reset_start: start=%b ready=%b required 1/0000", tx_start, req_ready);
      end
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();
      n_cmp++;
      if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: arb_busy=%b required 0", arb_busy); end
   endtask

   task automatic test_round_robin();
      int starts;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      req_data = 32'hA3A2_A1A0; req_valid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         int e;
         e = t % 4;
         tick();
         n_cmp++;
         if (req_ready !== (4'b0001 << e) || grant_id !== 2'(e) || tx_data !== (8'hA0 + 8'(e))) begin
            n_bad++; $display("FAIL rr_grant%0d: ready=%b id=%0d data=%h required %b/%0d/%h",
                              t, req_ready, grant_id, tx_data, 4'b0001 << e, e, 8'hA0 + 8'(e));
         end
         tick();
         starts = tx_start ? 1 : 0;
         tx_busy = 1'b1;
         for (int c = 0; c < 20; c++) begin
            tick();
            if (tx_start) starts++;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
               n_bad++; $display("FAIL rr_ready_while_busy%0d: got %b required 0000", t, req_ready);
            end
         end
         tx_busy = 1'b0;
         tick();
         if (tx_start) starts++;
         n_cmp++;
         if (starts != 1 || arb_busy !== 1'b0) begin
            n_bad++; $display("FAIL rr_starts%0d: starts=%0d arb_busy=%b required 1/0", t, starts, arb_busy);
         end
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_single();
      req_data = 32'h0055_0000; req_valid = 4'b0100;
      for (int t = 0; t < 3; t++) begin
         tick();
         n_cmp++;
         if (req_ready !== 4'b0100 || grant_id !== 2'd2 || tx_data !== 8'h55 || dut.rr_ptr !== 2'd3) begin
            n_bad++; $display("FAIL single_grant%0d: ready=%b id=%0d data=%h rr=%0d required 0100/2/55/3",
                              t, req_ready, grant_id, tx_data, dut.rr_ptr);
         end
         tick();
         n_cmp++;
         if (tx_start !== 1'b1) begin n_bad++; $display("FAIL single_start%0d: got %b required 1", t, tx_start); end
         tx_busy = 1'b1;
         repeat (3) begin
            tick();
            n_cmp++;
            if (req_ready !== 4'b0000) begin
               n_bad++; $display("FAIL single_ready_busy%0d: got %b required 0000", t, req_ready);
            end
         end
         tx_busy = 1'b0;
         tick();
      end
      req_data = 32'h7700_0000; req_valid = 4'b1000;
      tick();
      n_cmp++;
      if (req_ready !== 4'b1000 || grant_id !== 2'd3 || dut.rr_ptr !== 2'd0) begin
         n_bad++; $display("FAIL wrap_grant: ready=%b id=%0d rr=%0d required 1000/3/0",
                           req_ready, grant_id, dut.rr_ptr);
      end
      req_valid = 4'b0000;
      tick();
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      req_data = 32'h0000_C1C0; req_valid = 4'b0011;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0001 || tx_data !== 8'hC0) begin
         n_bad++; $display("FAIL to_grant: ready=%b data=%h required 0001/c0", req_ready, tx_data);
      end
      req_valid = 4'b0010;
      tick();
      n_cmp++;
      if (tx_start !== 1'b1) begin n_bad++; $display("FAIL to_start: got %b required 1", tx_start); end
      for (int c = 1; c < ACK_TIMEOUT; c++) begin
         tick();
         n_cmp++;
         if (timeout_err !== 1'b0 || arb_busy !== 1'b1) begin
            n_bad++; $display("FAIL to_early%0d: err=%b arb_busy=%b required 0/1", c, timeout_err, arb_busy);
         end
      end
      tick();
      n_cmp++;
      if (timeout_err !== 1'b1 || arb_busy !== 1'b0) begin
         n_bad++; $display("FAIL to_pulse: err=%b arb_busy=%b required 1/0", timeout_err, arb_busy);
      end
      tick();
      n_cmp++;
      if (req_ready !== 4'b0010 || tx_data !== 8'hC1 || grant_id !== 2'd1 || timeout_err !== 1'b0) begin
         n_bad++; $display("FAIL to_next_grant: ready=%b data=%h id=%0d err=%b required 0010/c1/1/0",
                           req_ready, tx_data, grant_id, timeout_err);
      end
      req_valid = 4'b0000;
      tick();
      tx_busy = 1'b1;
      tick();
      tx_busy = 1'b0;
      tick();
   endtask

   task automatic test_late_ack();
      req_data = 32'h00E2_0000; req_valid = 4'b0100;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0100 || tx_data !== 8'hE2) begin
         n_bad++; $display("FAIL late_grant: ready=%b data=%h required 0100/e2", req_ready, tx_data);
      end
      req_valid = 4'b0000;
      tick();
      for (int c = 1; c < ACK_TIMEOUT; c++) begin
         tick();
         n_cmp++;
         if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL late_early%0d: err=%b required 0", c, timeout_err); end
      end
      tx_busy = 1'b1;
      tick();
      n_cmp++;
      if (timeout_err !== 1'b0 || arb_busy !== 1'b1) begin
         n_bad++; $display("FAIL late_ack_edge: err=%b arb_busy=%b required 0/1", timeout_err, arb_busy);
      end
      tick();
      n_cmp++;
      if (timeout_err !== 1'b0 || arb_busy !== 1'b1) begin
         n_bad++; $display("FAIL late_wait_done: err=%b arb_busy=%b required 0/1", timeout_err, arb_busy);
      end
      tx_busy = 1'b0;
      tick();
      n_cmp++;
      if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL late_idle: arb_busy=%b required 0", arb_busy); end
   endtask

   task automatic test_withdraw();
      req_data = 32'h0000_D1D0; req_valid = 4'b0001;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
         n_bad++; $display("FAIL wd_grant: ready=%b id=%0d required 0001/0", req_ready, grant_id);
      end
      req_valid = 4'b0000;
      tick();
      tx_busy = 1'b1;
      tick();
      req_valid = 4'b0010;
      repeat (3) begin
         tick();
         n_cmp++;
         if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL wd_ready_raised: got %b required 0000", req_ready); end
      end
      req_valid = 4'b0000;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0000 || arb_busy !== 1'b1) begin
         n_bad++; $display("FAIL wd_dropped: ready=%b arb_busy=%b required 0000/1", req_ready, arb_busy);
      end
      tx_busy = 1'b0;
      tick();
      n_cmp++;
      if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL wd_arb_busy_fall: got %b required 0", arb_busy); end
      repeat (3) begin
         tick();
         n_cmp++;
         if (req_ready !== 4'b0000 || grant_id !== 2'd0 || arb_busy !== 1'b0) begin
            n_bad++; $display("FAIL wd_never_granted: ready=%b id=%0d arb_busy=%b required 0000/0/0",
                              req_ready, grant_id, arb_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_timeout();
      test_late_ack();
      test_withdraw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
